xor3_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered 3-operand XOR unit (`a^b^c`) among `NUM_REQ` requesters. Each requester offers an operand triple with a valid/ready handshake. The block grants exactly one requester at a time, captures its operands, computes the XOR in a registered stage, and returns the result tagged with the requester index and its reduction parity. It sits between the stimulus/control processes and the shared XOR datapath, and is the only writer of that datapath's inputs.

---
 rtl/xor3_share_arbiter.sv | 102 ++++++++++
 tb/tb_xor3_share_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/xor3_share_arbiter.sv
// Round-robin arbiter sharing one registered a^b^c unit among NUM_REQ requesters.
// One transaction in flight: grant (IDLE) -> compute (COMPUTE) -> hold result (RESP).
module xor3_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [IDW-1:0]           res_id,
  output logic                     res_parity,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } op_t;

  state_t                        state, state_nxt;
  logic [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v, c_v;
  logic [IDW-1:0]                last_grant, win, cand;
  logic                          win_found, grant;
  int                            rr_idx;
  op_t                           op_q;
  logic [WIDTH-1:0]              xor_w;

  assign a_v = req_a;
  assign b_v = req_b;
  assign c_v = req_c;

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    rr_idx    = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (int'(last_grant) + k) % NUM_REQ;
      cand   = IDW'(rr_idx);
      if (!win_found && req_valid[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  // rst_n gates req_ready so it drops with the asynchronous reset, like every other output.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant     = 1'b0;
    unique case (state)
      IDLE: if (win_found && rst_n) begin
        req_ready[win] = 1'b1;
        grant          = 1'b1;
        state_nxt      = COMPUTE;
      end
      COMPUTE: state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign xor_w     = op_q.a ^ op_q.b ^ op_q.c;
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      op_q       <= '0;
      res_id     <= '0;
      res_data   <= '0;
      res_parity <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        op_q       <= '{a: a_v[win], b: b_v[win], c: c_v[win]};
        res_id     <= win;
        last_grant <= win;
      end
      if (state == COMPUTE) begin
        res_data   <= xor_w;
        res_parity <= ^xor_w;
      end
    end
  end

endmodule

// File: tb/tb_xor3_share_arbiter.sv
// Randomized bench for xor3_share_arbiter against a transaction-level model:
// one outstanding job, round-robin pick, result visible two cycles after grant.
module tb_xor3_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int IDW     = $clog2(NUM_REQ);

  logic                          clk, rst_n, res_ready;
  logic [NUM_REQ-1:0]            req_valid, req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v, c_v;
  logic                          res_valid, res_parity, busy;
  logic [WIDTH-1:0]              res_data;
  logic [IDW-1:0]                res_id;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // transaction model state
  bit               pend;
  int               age;
  int               m_last;
  int               m_id;
  logic [WIDTH-1:0] m_data;
  int               gq_id[$];
  int               gq_cyc[$];

  xor3_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(a_v), .req_b(b_v), .req_c(c_v),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_parity(res_parity),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_res_valid"},  res_valid,  0);
    chk({tag, "_res_data"},   res_data,   0);
    chk({tag, "_res_id"},     res_id,     0);
    chk({tag, "_res_parity"}, res_parity, 0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_req_ready"},  req_ready,  0);
  endtask

  task automatic model_reset();
    pend   = 0;
    age    = 0;
    m_last = NUM_REQ - 1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
      c_v[i] = $urandom;
    end
  endtask

  // Called just after a negedge with inputs already driven; compares, advances the model
  // across the next rising edge, and returns at the following negedge.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_rdy;
    int w;
    bit showing;
    #1;
    exp_rdy = '0;
    w = -1;
    if (!pend) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_last + k) % NUM_REQ;
        if (w < 0 && req_valid[idx]) w = idx;
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    showing = pend && (age >= 2);
    chk("req_ready", req_ready, exp_rdy);
    chk("res_valid", res_valid, showing);
    chk("busy", busy, pend);
    if (showing) begin
      chk("res_data", res_data, m_data);
      chk("res_id", res_id, m_id);
      chk("res_parity", res_parity, $countones(m_data) % 2);
    end
    if (w >= 0) begin
      m_data = a_v[w] ^ b_v[w] ^ c_v[w];
      m_id   = w;
      m_last = w;
      pend   = 1;
      age    = 1;
      gq_id.push_back(w);
      gq_cyc.push_back(cyc);
    end else if (pend) begin
      if (showing && res_ready) pend = 0;
      else age++;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b1;
    a_v = '0; b_v = '0; c_v = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // all requesters valid continuously: 0,1,2,3,0 at 3-cycle spacing
    gq_id.delete(); gq_cyc.delete();
    req_valid = '1;
    repeat (15) begin rand_ops(); cycle(); end
    chk("rr_count", (gq_id.size() >= 5), 1);
    if (gq_id.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", gq_id[i], i % NUM_REQ);
        if (i > 0) chk("rr_spacing", gq_cyc[i] - gq_cyc[i-1], 3);
      end
    end
    req_valid = '0;
    repeat (4) cycle();

    // single request from requester 2
    req_valid = 4'b0100;
    a_v[2] = 32'h0; b_v[2] = 32'h1; c_v[2] = 32'h0;
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // wide operands on requester 1, then a=b=c=1
    req_valid = 4'b0010;
    a_v[1] = 32'hF0F0_0000; b_v[1] = 32'h0F0F_0000; c_v[1] = 32'h0000_FFFF;
    cycle();
    req_valid = '0;
    repeat (3) cycle();
    req_valid = 4'b0010;
    a_v[1] = 32'h1; b_v[1] = 32'h1; c_v[1] = 32'h1;
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // backpressure with requesters 0 and 3 pending
    res_ready = 1'b0;
    req_valid = 4'b1001;
    repeat (12) begin rand_ops(); cycle(); end
    res_ready = 1'b1;
    repeat (9) cycle();
    req_valid = '0;
    repeat (4) cycle();

    // operands change the cycle after acceptance
    req_valid = 4'b0001;
    a_v[0] = 32'h1234_5678; b_v[0] = 32'h0F0F_0F0F; c_v[0] = 32'hA5A5_0000;
    cycle();
    req_valid = '0;
    a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'h0; c_v[0] = 32'h5555_5555;
    repeat (3) cycle();

    // random traffic with random backpressure
    repeat (400) begin
      req_valid = NUM_REQ'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      rand_ops();
      cycle();
    end

    // reset while the result is being held
    res_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 10 && !(pend && age >= 2); i++) cycle();
    chk("reach_resp", (pend && age >= 2), 1);
    rst_n = 1'b0;
    #1 chk_reset_outs("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b0110;
    gq_id.delete(); gq_cyc.delete();
    cycle();
    chk("post_reset_grant", (gq_id.size() > 0) ? gq_id[0] : -1, 1);
    repeat (60) begin
      req_valid = NUM_REQ'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
